pll_reset_seq: RTL and testbench



---
 rtl/pll_reset_seq.sv | 120 ++++++++++++
 tb/tb_pll_reset_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset until lock, then releases the design reset after a stable-lock window.
// Optional lock-loss counter enabled by defining PLL_RESET_SEQ_LOSS_COUNT_EN.
module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clkin_25MHz,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count
);

  localparam int unsigned MAX_A   = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] C_PRST_LAST   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   w_pll_rst_nxt;
  logic                   w_sys_rst_nxt;
  logic                   w_ready_nxt;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // State, shared counter, lock synchronizer and registered outputs
  always_ff @(posedge clkin_25MHz or posedge rst) begin
    if (rst) begin
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_sync    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], locked};
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Next state; outputs follow the state being entered so they change on the transition edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == C_PRST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_s)                w_state_nxt = S_STABLE;
        else if (r_cnt == C_TO_LAST) w_state_nxt = S_PLL_RST;
      end
      S_STABLE: begin
        if (!w_lock_s)                   w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == C_STABLE_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) w_state_nxt = S_WAIT_LOCK;
      end
      default: w_state_nxt = S_PLL_RST;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    w_pll_rst_nxt = (w_state_nxt == S_PLL_RST);
    w_sys_rst_nxt = (w_state_nxt != S_RUN);
    w_ready_nxt   = (w_state_nxt == S_RUN);
  end

  assign pll_rst = r_pll_rst;
  assign sys_rst = r_sys_rst;
  assign ready   = r_ready;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [CNT_W-1:0] r_loss_cnt;
  logic             w_loss_evt;

  assign w_loss_evt = (r_state == S_RUN) && !w_lock_s;

  // Saturating count of RUN -> WAIT_LOCK transitions
  always_ff @(posedge clkin_25MHz or posedge rst) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != {CNT_W{1'b1}})) begin
      r_loss_cnt <= r_loss_cnt + CNT_W'(1);
    end
  end

  assign loss_count = r_loss_cnt;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: randomized lock patterns checked against a timer-based reference model.
module tb_pll_reset_seq;

  localparam int unsigned SYNC     = 2;
  localparam int unsigned STABLE   = 16;
  localparam int unsigned TIMEOUT  = 32;
  localparam int unsigned PRST     = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int          LOSS_MAX = (1 << CNT_W) - 1;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] loss_count;

  pll_reset_seq #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .PLL_RST_CYCLES(PRST),
    .CNT_W         (CNT_W)
  ) dut (
    .clkin_25MHz(clk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .loss_count (loss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pr;
    logic             sr;
    logic             rd;
    logic [CNT_W-1:0] lc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: remaining pulse time, elapsed wait time, consecutive lock count, running flag
  int   m_pulse;
  int   m_wait;
  int   m_stab;
  bit   m_run;
  int   m_loss;
  logic m_dly[$];

  task automatic model_reset();
    m_pulse = PRST;
    m_wait  = 0;
    m_stab  = -1;
    m_run   = 1'b0;
    m_loss  = 0;
    m_dly.delete();
    for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);
  endtask

  task automatic model_edge();
    logic ls;
    if (rst) begin
      model_reset();
    end else begin
      ls = m_dly.pop_front();
      m_dly.push_back(locked);
      if (m_pulse > 0) begin
        m_pulse--;
        m_wait = 0;
      end else if (m_run) begin
        if (!ls) begin
          m_run  = 1'b0;
          m_wait = 0;
          if (m_loss < LOSS_MAX) m_loss++;
        end
      end else if (m_stab >= 0) begin
        if (!ls) begin
          m_stab = -1;
          m_wait = 0;
        end else if (m_stab == STABLE - 1) begin
          m_stab = -1;
          m_run  = 1'b1;
        end else begin
          m_stab++;
        end
      end else begin
        if (ls) m_stab = 0;
        else if (m_wait == TIMEOUT - 1) m_pulse = PRST;
        else m_wait++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pr = (m_pulse > 0);
    e.sr = !m_run;
    e.rd = m_run;
    e.lc = LOSS_EN ? CNT_W'(m_loss) : '0;
    return e;
  endfunction

  // One clock: model the edge, then drive new inputs dly after it and queue the expected outputs
  task automatic step(input logic lk, input logic rv, input int dly);
    @(posedge clk);
    model_edge();
    #(dly);
    locked = lk;
    rst    = rv;
    if (rv) model_reset();
    sb_q.push_back(model_out());
  endtask

  task automatic hold(input logic lk, input int n);
    repeat (n) step(lk, 1'b0, 1);
  endtask

  task automatic check(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("pll_rst", int'(pll_rst), int'(mon_e.pr));
      check("sys_rst", int'(sys_rst), int'(mon_e.sr));
      check("ready", int'(ready), int'(mon_e.rd));
      check("loss_count", int'(loss_count), int'(mon_e.lc));
    end
  end

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b1, 1);

    // Release reset with no lock: periodic PLL reset pulses
    step(1'b0, 1'b0, 1);
    hold(1'b0, 90);

    // Clean lock and release
    hold(1'b1, 30);

    // Loss, then a one-cycle glitch while counting stable lock
    hold(1'b0, 5);
    hold(1'b1, 8);
    hold(1'b0, 1);
    hold(1'b1, 30);

    // Repeated losses in RUN to drive the counter into saturation
    repeat (300) begin
      hold(1'b0, int'($urandom_range(1, 3)));
      hold(1'b1, 22);
    end

    // Asynchronous reset between edges while running
    step(1'b1, 1'b1, 3);
    repeat (2) step(1'b1, 1'b1, 1);

    // Lock already present through the PLL reset pulse
    step(1'b1, 1'b0, 1);
    hold(1'b1, 30);

    // Random lock behaviour: short glitches and long runs
    repeat (600) step(1'($urandom_range(0, 9) != 0), 1'b0, 1);
    repeat (100) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
